// File: rtl/ysyx_22041211_ifu_pkg.sv
// Shared IFU definitions: FSM state encodings and the default boot PC.
package ysyx_22041211_ifu_pkg;

    typedef enum logic [1:0] {
        IFU_REQ  = 2'd0,
        IFU_WAIT = 2'd1,
        IFU_OUT  = 2'd2
    } ifu_state_e;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_22041211_ifu_perf.sv
// IFU performance counters: delivered instructions and fetch stall cycles.
// Only instantiated when YSYX_22041211_IFU_PERF_EN is defined.
module ysyx_22041211_ifu_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_fire,
    input  logic        stall_cyc,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    // Both counters wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (fetch_fire) fetch_cnt <= fetch_cnt + 32'd1;
            if (stall_cyc)  stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/ysyx_22041211_ifu.sv
// Multi-cycle instruction fetch unit: one outstanding imem request, redirect
// at any time, stale responses dropped. Optional YSYX_22041211_IFU_PERF_EN adds counters.
module ysyx_22041211_ifu
    import ysyx_22041211_ifu_pkg::*;
#(
    parameter int                  ADDR_LEN = 32,
    parameter int                  DATA_LEN = 32,
    parameter logic [ADDR_LEN-1:0] RESET_PC = ADDR_LEN'(IFU_RESET_PC)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [ADDR_LEN-1:0] imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [DATA_LEN-1:0] imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [ADDR_LEN-1:0] redirect_target,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [ADDR_LEN-1:0] id_pc,
    output logic [DATA_LEN-1:0] id_inst
`ifdef YSYX_22041211_IFU_PERF_EN
   ,output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    ifu_state_e          state, state_n;
    logic [ADDR_LEN-1:0] pc, pc_n;
    logic [DATA_LEN-1:0] inst_q, inst_n;
    logic                kill, kill_n;
    logic [ADDR_LEN-1:0] target;

    assign target = redirect_target & ~ADDR_LEN'(3);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IFU_REQ;
            pc     <= RESET_PC;
            kill   <= 1'b0;
            inst_q <= '0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            kill   <= kill_n;
            inst_q <= inst_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        kill_n  = kill;
        inst_n  = inst_q;
        case (state)
            IFU_REQ: begin
                if (redirect_valid) pc_n = target;
                if (imem_req_ready) begin
                    state_n = IFU_WAIT;
                    // The accepted request carried the old pc; drop its response.
                    if (redirect_valid) kill_n = 1'b1;
                end
            end
            IFU_WAIT: begin
                if (redirect_valid) begin
                    pc_n   = target;
                    kill_n = 1'b1;
                end
                if (imem_rsp_valid) begin
                    if (!kill && !redirect_valid) begin
                        inst_n  = imem_rsp_data;
                        state_n = IFU_OUT;
                    end else begin
                        kill_n  = 1'b0;
                        state_n = IFU_REQ;
                    end
                end
            end
            IFU_OUT: begin
                if (redirect_valid) begin
                    pc_n    = target;
                    state_n = IFU_REQ;
                end else if (id_ready) begin
                    pc_n    = pc + ADDR_LEN'(4);
                    state_n = IFU_REQ;
                end
            end
            default: state_n = IFU_REQ;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        id_valid       = 1'b0;
        if (rst) begin
            imem_req_valid = (state == IFU_REQ);
            id_valid       = (state == IFU_OUT);
        end
    end

    assign imem_req_addr = pc;
    assign id_pc         = pc;
    assign id_inst       = inst_q;

`ifdef YSYX_22041211_IFU_PERF_EN
    ysyx_22041211_ifu_perf u_perf (
        .clk        (clk),
        .rst        (rst),
        .fetch_fire (id_valid & id_ready),
        .stall_cyc  (rst && (state == IFU_REQ || state == IFU_WAIT)),
        .fetch_cnt  (perf_fetch_cnt),
        .stall_cnt  (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Directed self-checking bench for ysyx_22041211_ifu (perf checks follow
// YSYX_22041211_IFU_PERF_EN).
module tb_ysyx_22041211_ifu;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
`ifdef YSYX_22041211_IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    ysyx_22041211_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_pc           (id_pc),
        .id_inst         (id_inst)
`ifdef YSYX_22041211_IFU_PERF_EN
       ,.perf_fetch_cnt  (perf_fetch_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; sample/drive 1ns after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_target = '0; id_ready = 1'b0;
        step(); step();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_pc", id_pc, 32'h8000_0000);
        check("rst_id_inst", id_inst, 32'h0);
`ifdef YSYX_22041211_IFU_PERF_EN
        check("rst_fetch_cnt", perf_fetch_cnt, 32'd0);
        check("rst_stall_cnt", perf_stall_cnt, 32'd0);
`endif

        // Zero-wait fetch: REQ c0, WAIT c1, OUT c2.
        rst = 1'b1; imem_req_ready = 1'b1; #1;
        check("c0_req_valid", 32'(imem_req_valid), 32'd1);
        check("c0_req_addr", imem_req_addr, 32'h8000_0000);
        step();
        check("c1_req_valid", 32'(imem_req_valid), 32'd0);
        check("c1_id_valid", 32'(id_valid), 32'd0);
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0413;
        step();
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'hFFFF_FFFF;
        check("c2_id_valid", 32'(id_valid), 32'd1);
        check("c2_id_pc", id_pc, 32'h8000_0000);
        check("c2_id_inst", id_inst, 32'h0000_0413);

        // Decoder back-pressure: output held stable, no new request.
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_id_valid", 32'(id_valid), 32'd1);
            check("hold_id_pc", id_pc, 32'h8000_0000);
            check("hold_id_inst", id_inst, 32'h0000_0413);
            check("hold_no_req", 32'(imem_req_valid), 32'd0);
        end
`ifdef YSYX_22041211_IFU_PERF_EN
        check("hold_stall_cnt", perf_stall_cnt, 32'd2);
        check("hold_fetch_cnt", perf_fetch_cnt, 32'd0);
`endif
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        check("next_id_valid", 32'(id_valid), 32'd0);
        check("next_req_valid", 32'(imem_req_valid), 32'd1);
        check("next_req_addr", imem_req_addr, 32'h8000_0004);
`ifdef YSYX_22041211_IFU_PERF_EN
        check("deliver1_fetch_cnt", perf_fetch_cnt, 32'd1);
`endif

        // Redirect in WAIT kills the in-flight response.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h8000_0102;
        step();
        redirect_valid = 1'b0;
        check("kill_req_addr", imem_req_addr, 32'h8000_0100);
        check("kill_req_valid", 32'(imem_req_valid), 32'd0);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        check("stale_id_valid", 32'(id_valid), 32'd0);
        check("stale_req_valid", 32'(imem_req_valid), 32'd1);
        check("stale_req_addr", imem_req_addr, 32'h8000_0100);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
        step();
        imem_rsp_valid = 1'b0;
        check("redir_id_valid", 32'(id_valid), 32'd1);
        check("redir_id_pc", id_pc, 32'h8000_0100);
        check("redir_id_inst", id_inst, 32'h1234_5678);

        // Redirect beats pc+4 but the handshake still counts.
        id_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h8000_0020;
        step();
        id_ready = 1'b0; redirect_valid = 1'b0;
        check("out_redir_id_valid", 32'(id_valid), 32'd0);
        check("out_redir_req_addr", imem_req_addr, 32'h8000_0020);
`ifdef YSYX_22041211_IFU_PERF_EN
        check("deliver2_fetch_cnt", perf_fetch_cnt, 32'd2);
`endif

        // Redirect in unaccepted REQ, low bits masked, then pc+4 wrap.
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        check("req_redir_valid", 32'(imem_req_valid), 32'd1);
        check("req_redir_addr", imem_req_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0073;
        step();
        imem_rsp_valid = 1'b0;
        check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_id_inst", id_inst, 32'h0010_0073);
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        check("wrap_req_addr", imem_req_addr, 32'h0000_0000);
        check("wrap_req_valid", 32'(imem_req_valid), 32'd1);

        // Reset while WAIT; a late response after release must be ignored.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        check("pre_rst_wait", 32'(imem_req_valid), 32'd0);
        rst = 1'b0;
        step();
        check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("mid_rst_id_valid", 32'(id_valid), 32'd0);
        check("mid_rst_id_pc", id_pc, 32'h8000_0000);
        check("mid_rst_id_inst", id_inst, 32'h0);
`ifdef YSYX_22041211_IFU_PERF_EN
        check("mid_rst_fetch_cnt", perf_fetch_cnt, 32'd0);
        check("mid_rst_stall_cnt", perf_stall_cnt, 32'd0);
`endif
        rst = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBADB_AD00; #1;
        check("rel_req_valid", 32'(imem_req_valid), 32'd1);
        check("rel_req_addr", imem_req_addr, 32'h8000_0000);
        step();
        imem_rsp_valid = 1'b0;
        check("late_rsp_id_valid", 32'(id_valid), 32'd0);
        check("late_rsp_req_valid", 32'(imem_req_valid), 32'd1);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
        step();
        imem_rsp_valid = 1'b0;
        check("post_rst_id_valid", 32'(id_valid), 32'd1);
        check("post_rst_id_pc", id_pc, 32'h8000_0000);
        check("post_rst_id_inst", id_inst, 32'h0000_0013);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
